// File: rtl/command_fifo_control.sv
// Host command front end: synchronises the host strobe, queues command/data pairs
// and issues them to the GPU under a small pacing/frame-lock state machine.
module command_fifo_control #(
    parameter int CMD_W        = 16,
    parameter int DATA_W       = 16,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                     gpuClk,
    input  logic                     rst,
    input  logic                     chipSelect,
    input  logic                     commandClk,
    input  logic [CMD_W-1:0]         inputCommand,
    input  logic [DATA_W-1:0]        inputData,
    input  logic                     gpuBusyController,
    input  logic                     frameRendering,
    output logic                     readyBusy,
    output logic [CMD_W-1:0]         gpuCommand,
    output logic [DATA_W-1:0]        gpuData,
    output logic                     gpuCommandValid,
    output logic [$clog2(DEPTH):0]   fifoCount,
    output logic                     overflowErr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    FULL_LEVEL   = CW'(DEPTH);
    localparam logic [CW-1:0]    AFULL_LEVEL  = CW'(DEPTH - AFULL_MARGIN);
    localparam logic [CMD_W-1:0] UPDATE_FRAME = CMD_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, FRAME_LOCK} state_t;

    state_t               state;
    logic                 seen_high;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                 sync_last_q;
    logic                 armed_q;
    logic                 capture;

    logic [CMD_W-1:0]     cmd_mem  [DEPTH];
    logic [DATA_W-1:0]    data_mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count_q;
    logic                 push_req;
    logic                 push;
    logic                 pop;
    logic                 full;

    // Capture is only armed once the last stage has held a genuinely sampled 0,
    // so a strobe held high across reset release does not produce a command.
    always_ff @(posedge gpuClk or negedge rst) begin
        if (!rst) begin
            sync_q      <= '0;
            fill_q      <= '0;
            sync_last_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], commandClk};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sync_last_q <= sync_q[SYNC_STAGES-1];
            if (fill_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES-1])
                armed_q <= 1'b1;
        end
    end

    assign capture  = armed_q & sync_q[SYNC_STAGES-1] & ~sync_last_q;
    assign push_req = capture & chipSelect & (inputCommand != '0);
    assign pop      = (state == ISSUE);
    assign full     = (count_q == FULL_LEVEL);
    assign push     = push_req & (~full | pop);

    always_ff @(posedge gpuClk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflowErr <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && full && !pop)
                overflowErr <= 1'b1;
        end
    end

    always_ff @(posedge gpuClk) begin
        if (push) begin
            cmd_mem[wr_ptr]  <= inputCommand;
            data_mem[wr_ptr] <= inputData;
        end
    end

    assign fifoCount = count_q;

    always_ff @(posedge gpuClk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            seen_high       <= 1'b0;
            gpuCommand      <= '0;
            gpuData         <= '0;
            gpuCommandValid <= 1'b0;
            readyBusy       <= 1'b1;
        end else begin
            gpuCommandValid <= 1'b0;
            readyBusy       <= (count_q >= AFULL_LEVEL) || frameRendering || (state == FRAME_LOCK);
            case (state)
                IDLE: begin
                    if (count_q != '0 && !gpuBusyController && !frameRendering)
                        state <= ISSUE;
                end
                ISSUE: begin
                    gpuCommand      <= cmd_mem[rd_ptr];
                    gpuData         <= data_mem[rd_ptr];
                    gpuCommandValid <= 1'b1;
                    seen_high       <= 1'b0;
                    state <= (cmd_mem[rd_ptr] == UPDATE_FRAME) ? FRAME_LOCK : WAIT_BUSY;
                end
                WAIT_BUSY: state <= IDLE;
                FRAME_LOCK: begin
                    if (frameRendering)
                        seen_high <= 1'b1;
                    else if (seen_high)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_command_fifo_control.sv
// Self-checking bench for command_fifo_control: table-driven single writes plus
// burst, overflow, frame-lock and reset sequences, with an issue scoreboard.
module tb_command_fifo_control;

    localparam int SYNC = 2;

    logic        gpuClk = 1'b0;
    logic        rst;
    logic        chipSelect;
    logic        commandClk;
    logic [15:0] inputCommand;
    logic [15:0] inputData;
    logic        gpuBusyController;
    logic        frameRendering;
    logic        readyBusy;
    logic [15:0] gpuCommand;
    logic [15:0] gpuData;
    logic        gpuCommandValid;
    logic [3:0]  fifoCount;
    logic        overflowErr;

    command_fifo_control #(
        .CMD_W(16), .DATA_W(16), .DEPTH(8), .AFULL_MARGIN(2), .SYNC_STAGES(SYNC)
    ) dut (
        .gpuClk(gpuClk), .rst(rst), .chipSelect(chipSelect), .commandClk(commandClk),
        .inputCommand(inputCommand), .inputData(inputData),
        .gpuBusyController(gpuBusyController), .frameRendering(frameRendering),
        .readyBusy(readyBusy), .gpuCommand(gpuCommand), .gpuData(gpuData),
        .gpuCommandValid(gpuCommandValid), .fifoCount(fifoCount), .overflowErr(overflowErr)
    );

    always #5 gpuClk = ~gpuClk;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] data;
        logic        cs;
        int unsigned exp_issues;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vecs[6];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned strobe_cnt = 0;
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;
    bit          have_prev = 0;
    bit          spacing_chk = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge gpuClk) cyc++;

    // Scoreboard consumer: every strobe must match the oldest expected entry.
    always @(negedge gpuClk) begin
        if (gpuCommandValid === 1'b1) begin
            strobe_cnt++;
            if (sbq.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_strobe: got cmd 0x%0h with empty scoreboard", gpuCommand);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("issue_cmd", gpuCommand, e.cmd);
                check("issue_data", gpuData, e.data);
            end
            if (spacing_chk && have_prev) check("issue_spacing", cyc - last_cyc, 3);
            have_prev = 1;
            last_cyc  = cyc;
        end
    end

    task automatic host_write(input logic [15:0] c, input logic [15:0] d, input logic cs);
        @(negedge gpuClk);
        inputCommand = c;
        inputData    = d;
        chipSelect   = cs;
        commandClk   = 1'b1;
        repeat (SYNC + 2) @(posedge gpuClk);
        @(negedge gpuClk);
        commandClk = 1'b0;
        repeat (3) @(negedge gpuClk);
    endtask

    task automatic expect_write(input logic [15:0] c, input logic [15:0] d);
        exp_t e;
        e.cmd  = c;
        e.data = d;
        sbq.push_back(e);
        host_write(c, d, 1'b1);
    endtask

    task automatic wait_strobes(input int unsigned target, input int unsigned budget);
        int unsigned n = 0;
        while (strobe_cnt < target && n < budget) begin
            @(negedge gpuClk);
            #1;
            n++;
        end
        check("strobe_count", strobe_cnt, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int unsigned base;

        vecs[0] = '{cmd: 16'h8801, data: 16'h1234, cs: 1'b1, exp_issues: 1};
        vecs[1] = '{cmd: 16'h0000, data: 16'hFFFF, cs: 1'b1, exp_issues: 0};
        vecs[2] = '{cmd: 16'h1234, data: 16'hABCD, cs: 1'b0, exp_issues: 0};
        vecs[3] = '{cmd: 16'hFFFF, data: 16'h0000, cs: 1'b1, exp_issues: 1};
        vecs[4] = '{cmd: 16'h4321, data: 16'h5A5A, cs: 1'b1, exp_issues: 1};
        vecs[5] = '{cmd: 16'h0002, data: 16'hC3C3, cs: 1'b1, exp_issues: 1};

        rst = 1'b0; chipSelect = 1'b0; commandClk = 1'b0;
        inputCommand = '0; inputData = '0;
        gpuBusyController = 1'b0; frameRendering = 1'b0;
        repeat (3) @(negedge gpuClk);
        check("reset_readyBusy", readyBusy, 1);
        check("reset_fifoCount", fifoCount, 0);
        check("reset_valid", gpuCommandValid, 0);
        check("reset_gpuCommand", gpuCommand, 0);
        check("reset_gpuData", gpuData, 0);
        check("reset_overflowErr", overflowErr, 0);
        rst = 1'b1;
        repeat (5) @(negedge gpuClk);
        check("idle_readyBusy", readyBusy, 0);

        for (int i = 0; i < 6; i++) begin
            base = strobe_cnt;
            if (vecs[i].exp_issues != 0) begin
                exp_t e;
                e.cmd  = vecs[i].cmd;
                e.data = vecs[i].data;
                sbq.push_back(e);
            end
            host_write(vecs[i].cmd, vecs[i].data, vecs[i].cs);
            repeat (6) @(negedge gpuClk);
            check("vec_issues", strobe_cnt - base, vecs[i].exp_issues);
            check("vec_fifoCount", fifoCount, 0);
        end
        check("hold_gpuCommand", gpuCommand, 16'h0002);
        check("hold_gpuData", gpuData, 16'hC3C3);

        // Burst of 7 while the GPU is busy, then drained back-to-back.
        gpuBusyController = 1'b1;
        base = strobe_cnt;
        for (int i = 1; i <= 7; i++) begin
            expect_write(16'h1000 + 16'(i), 16'hA000 + 16'(i));
            check("burst_fifoCount", fifoCount, i);
            check("burst_readyBusy", readyBusy, (i >= 6) ? 1 : 0);
        end
        check("burst_no_issue", strobe_cnt - base, 0);
        have_prev = 0;
        spacing_chk = 1;
        gpuBusyController = 1'b0;
        wait_strobes(base + 7, 60);
        spacing_chk = 0;
        repeat (4) @(negedge gpuClk);
        check("burst_drained", fifoCount, 0);
        check("burst_hold_cmd", gpuCommand, 16'h1007);

        // Overflow: ninth command dropped while full.
        gpuBusyController = 1'b1;
        base = strobe_cnt;
        for (int i = 1; i <= 8; i++) expect_write(16'h2000 + 16'(i), 16'hB000 + 16'(i));
        check("ovf_before", overflowErr, 0);
        host_write(16'h2009, 16'hB009, 1'b1);
        check("ovf_fifoCount", fifoCount, 8);
        check("ovf_flag", overflowErr, 1);
        gpuBusyController = 1'b0;
        wait_strobes(base + 8, 80);
        repeat (4) @(negedge gpuClk);
        check("ovf_drained", fifoCount, 0);
        check("ovf_sticky", overflowErr, 1);

        // No-op discard and frame lock.
        base = strobe_cnt;
        host_write(16'h0000, 16'h1111, 1'b1);
        repeat (6) @(negedge gpuClk);
        check("noop_fifoCount", fifoCount, 0);
        check("noop_issues", strobe_cnt - base, 0);
        gpuBusyController = 1'b1;
        expect_write(16'h0001, 16'h0F0F);
        expect_write(16'h4800, 16'hF0F0);
        check("frame_fifoCount", fifoCount, 2);
        gpuBusyController = 1'b0;
        wait_strobes(base + 1, 20);
        repeat (20) @(negedge gpuClk);
        check("frame_locked_issues", strobe_cnt - base, 1);
        check("frame_locked_count", fifoCount, 1);
        check("frame_locked_ready", readyBusy, 1);
        frameRendering = 1'b1;
        repeat (4) @(negedge gpuClk);
        check("frame_render_issues", strobe_cnt - base, 1);
        check("frame_render_ready", readyBusy, 1);
        frameRendering = 1'b0;
        wait_strobes(base + 2, 20);
        repeat (4) @(negedge gpuClk);
        check("frame_after_count", fifoCount, 0);

        // Reset with entries queued, strobe held high across release.
        gpuBusyController = 1'b1;
        base = strobe_cnt;
        for (int i = 1; i <= 3; i++) host_write(16'h3000 + 16'(i), 16'hD000 + 16'(i), 1'b1);
        check("rst_pre_count", fifoCount, 3);
        @(negedge gpuClk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_count", fifoCount, 0);
        check("rst_async_ready", readyBusy, 1);
        check("rst_async_ovf", overflowErr, 0);
        inputCommand = 16'h5555; inputData = 16'h6666; chipSelect = 1'b1; commandClk = 1'b1;
        repeat (3) @(negedge gpuClk);
        rst = 1'b1;
        gpuBusyController = 1'b0;
        repeat (12) @(negedge gpuClk);
        check("rst_no_capture", fifoCount, 0);
        check("rst_no_strobe", strobe_cnt - base, 0);
        commandClk = 1'b0;
        repeat (4) @(negedge gpuClk);
        expect_write(16'h7777, 16'h0777);
        wait_strobes(base + 1, 20);
        check("scoreboard_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/command_fifo_control.md
COMMAND_FIFO_CONTROL -- requirements
Module: command_fifo_control

Interface
REQ-001 SHALL have parameter CMD_W, default 16, command word width (>=4).
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter DEPTH, default 8, command FIFO entries (power of 2, >=4).
REQ-004 SHALL have parameter AFULL_MARGIN, default 2, free entries below which readyBusy asserts (1..DEPTH-1).
REQ-005 SHALL have parameter SYNC_STAGES, default 2, commandClk synchroniser depth (>=2).
REQ-006 SHALL have port gpuClk  input  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port chipSelect  input  1  active-high select; commands ignored when low.
REQ-009 SHALL have port commandClk  input  1  asynchronous host command strobe.
REQ-010 SHALL have port inputCommand  input  CMD_W  host command word.
REQ-011 SHALL have port inputData  input  DATA_W  host data word.
REQ-012 SHALL have port gpuBusyController  input  1  GPU controller busy.
REQ-013 SHALL have port frameRendering  input  1  frame render in progress.
REQ-014 SHALL have port readyBusy  output  1  high = host must not issue commands.
REQ-015 SHALL have port gpuCommand  output  CMD_W  command issued to GPU.
REQ-016 SHALL have port gpuData  output  DATA_W  data issued to GPU.
REQ-017 SHALL have port gpuCommandValid  output  1  one-cycle issue strobe.
REQ-018 SHALL have port fifoCount  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 SHALL have port overflowErr  output  1  sticky dropped-command flag.

Function
REQ-020 SHALL synchronise commandClk through SYNC_STAGES flops; a capture event SHALL occur in the cycle the last stage first reads 1 after 0.
REQ-021 SHALL sample inputCommand/inputData on the capture event; host holds them stable for SYNC_STAGES+2 gpuClk cycles after its commandClk rising edge.
REQ-022 SHALL ignore the capture event when chipSelect is low in the capture cycle.
REQ-023 SHALL discard, without enqueueing, any captured command equal to all-zeros (no-op).
REQ-024 SHALL enqueue a captured command/data pair when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle (count then unchanged).
REQ-025 SHALL drop the pair and set overflowErr when full with no same-cycle pop; overflowErr clears only on reset.
REQ-026 SHALL drive readyBusy = (count >= DEPTH-AFULL_MARGIN) OR frameRendering OR (state==FRAME_LOCK), registered, one-cycle lag.
REQ-027 SHALL implement states IDLE, ISSUE, WAIT_BUSY, FRAME_LOCK.
REQ-028 IDLE->ISSUE when count>0 AND !gpuBusyController AND !frameRendering.
REQ-029 ISSUE: pop head entry, register it onto gpuCommand/gpuData, pulse gpuCommandValid for exactly one cycle; next state FRAME_LOCK if entry is update-frame (top two bits 00, remaining bits ==1), else WAIT_BUSY.
REQ-030 WAIT_BUSY: hold one cycle unconditionally, then IDLE; guarantees at most one issue per three cycles.
REQ-031 FRAME_LOCK: wait until frameRendering seen high and then low (either order of detection counts only after entry), then IDLE; no issues while in FRAME_LOCK.
REQ-032 gpuCommand/gpuData SHALL hold last issued value between strobes.
REQ-033 FIFO pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-034 fifoCount SHALL update in the cycle after push/pop; simultaneous push+pop leaves it unchanged.

Reset
REQ-035 On rst low, asynchronously: FIFO empty, pointers 0, fifoCount=0, state IDLE, synchroniser flops 0, gpuCommand=0, gpuData=0, gpuCommandValid=0, overflowErr=0, readyBusy=1.
REQ-036 Reset mid-operation SHALL discard all queued entries and any pending capture; first capture after release requires a fresh 0->1 commandClk transition.

Verification
REQ-037 Write 0x8801/0x1234 with gpuBusyController=0 -> gpuCommandValid pulses once, gpuCommand=0x8801, gpuData=0x1234, fifoCount back to 0.
REQ-038 Hold gpuBusyController=1, write 7 commands (DEPTH=8) -> readyBusy high once count reaches 6, no issues; release busy -> 7 strobes in order, spacing 3 cycles.
REQ-039 Write 9 commands while busy -> 9th dropped, overflowErr=1, fifoCount=8; first issued is command 1.
REQ-040 Write 0x0000 -> nothing enqueued; write 0x0001 then 0x4800 -> 0x0001 issued, 0x4800 held until frameRendering pulses high then low.
REQ-041 chipSelect=0 during capture -> no enqueue; rst low with 3 queued -> fifoCount=0, readyBusy=1 immediately, no strobe after release.
